// File: rtl/rr_record_packer_if.sv
// Record packer handshake bundle: transaction-log input beat and packed record output.
// master = producer/consumer side (testbench or neighbours), slave = the packer itself.
interface rr_record_packer_if #(
    parameter int LOGB_CHANNEL_CNT = 4,
    parameter int LOGE_CHANNEL_CNT = 4,
    parameter int CH_W             = 64
);
    localparam int FULL_WIDTH   = LOGB_CHANNEL_CNT * CH_W
                                + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;
    localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1);

    logic                             in_valid;
    logic                             in_ready;
    logic [LOGB_CHANNEL_CNT-1:0]      in_logb_valid;
    logic [LOGE_CHANNEL_CNT-1:0]      in_loge_valid;
    logic [LOGB_CHANNEL_CNT*CH_W-1:0] in_logb_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [FULL_WIDTH-1:0]            out_data;
    logic [OFFSET_WIDTH-1:0]          out_len;

    modport master (
        output in_valid, in_logb_valid, in_loge_valid, in_logb_data, out_ready,
        input  in_ready, out_valid, out_data, out_len
    );

    modport slave (
        input  in_valid, in_logb_valid, in_loge_valid, in_logb_data, out_ready,
        output in_ready, out_valid, out_data, out_len
    );
endinterface

// File: rtl/rr_record_packer.sv
// Two-stage log-beat compactor feeding the AXI storage backend.
// RR_PACKER_STATS_EN enables the pkt_cnt / drop_cnt statistics counters.
module rr_record_packer #(
    parameter int LOGB_CHANNEL_CNT = 4,
    parameter int LOGE_CHANNEL_CNT = 4,
    parameter int CH_W             = 64
) (
    input  logic                clk,
    input  logic                sync_rst,
    rr_record_packer_if.slave   bus,
    output logic                idle,
    output logic [31:0]         pkt_cnt,
    output logic [31:0]         drop_cnt
);
    localparam int LB  = LOGB_CHANNEL_CNT;
    localparam int LE  = LOGE_CHANNEL_CNT;
    localparam int HDR = LB + LE;
    localparam int FW  = LB * CH_W + HDR;
    localparam int OW  = $clog2(FW + 1);
    localparam int RW  = $clog2(LB + 1);

    logic             s1_v;
    logic [LB-1:0]    s1_logb;
    logic [LE-1:0]    s1_loge;
    logic [LB*CH_W-1:0] s1_data;
    logic [RW-1:0]    s1_rank [LB];
    logic [RW-1:0]    s1_cnt;

    logic             s2_v;
    logic [FW-1:0]    s2_data;
    logic [OW-1:0]    s2_len;

    logic [RW-1:0]    rank_d [LB];
    logic [RW-1:0]    cnt_d;
    logic [FW-1:0]    pack_d;
    logic [OW-1:0]    len_d;

    logic s1_adv;
    logic s2_adv;
    logic in_fire;
    logic in_empty;

    assign s2_adv   = !s2_v | bus.out_ready;
    assign s1_adv   = !s1_v | s2_adv;
    assign in_fire  = bus.in_valid & s1_adv;
    assign in_empty = ~|bus.in_logb_valid & ~|bus.in_loge_valid;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_v;
    assign bus.out_data  = s2_data;
    assign bus.out_len   = s2_len;
    assign idle          = !s1_v & !s2_v;

    // Rank = number of valid logb channels strictly below channel i.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < LB; i++) begin
            rank_d[i] = cnt_d;
            cnt_d     = cnt_d + RW'(bus.in_logb_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            s1_v <= 1'b0;
        end else if (s1_adv) begin
            s1_v <= bus.in_valid & !in_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_logb <= bus.in_logb_valid;
            s1_loge <= bus.in_loge_valid;
            s1_data <= bus.in_logb_data;
            s1_cnt  <= cnt_d;
            for (int i = 0; i < LB; i++) begin
                s1_rank[i] <= rank_d[i];
            end
        end
    end

    always_comb begin
        pack_d = FW'({s1_loge, s1_logb});
        for (int i = 0; i < LB; i++) begin
            if (s1_logb[i]) begin
                pack_d = pack_d
                       | (FW'(s1_data[i*CH_W +: CH_W])
                          << (HDR + int'(s1_rank[i]) * CH_W));
            end
        end
        len_d = OW'(HDR) + OW'(s1_cnt) * OW'(CH_W);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_len  <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= pack_d;
                s2_len  <= len_d;
            end
        end
    end

`ifdef RR_PACKER_STATS_EN
    logic [31:0] pkt_q;
    logic [31:0] drop_q;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (s2_v & bus.out_ready) begin
                pkt_q <= pkt_q + 32'd1;
            end
            if (in_fire & in_empty) begin
                drop_q <= drop_q + 32'd1;
            end
        end
    end

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
`else
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_rr_record_packer.sv
// Scoreboard bench for rr_record_packer (LOGB=4, LOGE=4, CH_W=8).
// Driver pushes model records on acceptance; a negedge monitor pops and compares.
module tb_rr_record_packer;
    localparam int LB = 4;
    localparam int LE = 4;
    localparam int CW = 8;
    localparam int FW = LB * CW + LB + LE;
    localparam int OW = $clog2(FW + 1);

    typedef struct {
        logic [FW-1:0] d;
        logic [OW-1:0] l;
    } rec_t;

    logic        clk = 1'b0;
    logic        sync_rst = 1'b1;
    logic        idle;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    rr_record_packer_if #(
        .LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .CH_W(CW)
    ) bus ();

    rr_record_packer #(
        .LOGB_CHANNEL_CNT(LB), .LOGE_CHANNEL_CNT(LE), .CH_W(CW)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus),
        .idle     (idle),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    rec_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_pkt = 0;
    int   exp_drop = 0;
    int   accepted = 0;
    bit   rnd = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sx(int v);
`ifdef RR_PACKER_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Reference: header bitmaps, then valid payloads in channel order.
    function automatic rec_t model(logic [3:0] b, logic [3:0] e,
                                   logic [31:0] d);
        rec_t r;
        int   pos;
        r.d      = '0;
        r.d[3:0] = b;
        r.d[7:4] = e;
        pos      = LB + LE;
        for (int c = 0; c < LB; c++) begin
            if (b[c]) begin
                r.d = r.d | (FW'(d[c*CW +: CW]) << pos);
                pos += CW;
            end
        end
        r.l = OW'(pos);
        return r;
    endfunction

    task automatic send(logic [3:0] b, logic [3:0] e, logic [31:0] d);
        bit ok;
        ok = 0;
        bus.in_valid      = 1'b1;
        bus.in_logb_valid = b;
        bus.in_loge_valid = e;
        bus.in_logb_data  = d;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                accepted++;
                if (b == 4'd0 && e == 4'd0) exp_drop++;
                else q.push_back(model(b, e, d));
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        q.delete();
        exp_pkt  = 0;
        exp_drop = 0;
    endtask

    task automatic drain(string name);
        for (int k = 0; k < 400; k++) begin
            if (q.size() == 0 && idle) break;
            @(negedge clk);
        end
        chk({name, "_drain"}, 64'(q.size() == 0 && idle), 64'd1);
        chk({name, "_pkt"}, 64'(pkt_cnt), 64'(sx(exp_pkt)));
        chk({name, "_drop"}, 64'(drop_cnt), 64'(sx(exp_drop)));
    endtask

    task automatic latency2(string name);
        @(negedge clk);
        chk({name, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk({name, "_lat2"}, 64'(bus.out_valid), 64'd1);
    endtask

    bit            stall = 0;
    logic [FW-1:0] pd;
    logic [OW-1:0] pl;
    rec_t          mr;

    always @(negedge clk) begin
        if (sync_rst) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_data", 64'(bus.out_data), 64'(pd));
                chk("hold_len", 64'(bus.out_len), 64'(pl));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(bus.out_data), 64'd0 - 64'd1);
                end else begin
                    mr = q.pop_front();
                    chk("out_data", 64'(bus.out_data), 64'(mr.d));
                    chk("out_len", 64'(bus.out_len), 64'(mr.l));
                    exp_pkt++;
                end
            end
            stall = bus.out_valid && !bus.out_ready;
            pd    = bus.out_data;
            pl    = bus.out_len;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [3:0]  b;
        logic [3:0]  e;
        bus.in_valid      = 1'b0;
        bus.in_logb_valid = '0;
        bus.in_loge_valid = '0;
        bus.in_logb_data  = '0;
        bus.out_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_len", 64'(bus.out_len), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_pkt", 64'(pkt_cnt), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;

        send(4'b0101, 4'b0010, 32'h00CC_00AA);
        latency2("t1");
        drain("t1");
        @(posedge clk);
        #1;

        send(4'b0000, 4'b0000, 32'h1234_5678);
        @(negedge clk);
        chk("t2_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t2_idle", 64'(idle), 64'd1);
        chk("t2_drop", 64'(drop_cnt), 64'(sx(1)));
        @(posedge clk);
        #1;

        send(4'b0000, 4'b1000, 32'hFFFF_FFFF);
        send(4'b1111, 4'b0000, 32'h4433_2211);
        drain("t34");
        @(posedge clk);
        #1;

        do_reset();
        bus.out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(4'b0001, 4'b0001, 32'h0000_0011);
                send(4'b0010, 4'b0011, 32'h0000_2200);
                send(4'b0100, 4'b0100, 32'h0033_0000);
                send(4'b1000, 4'b0101, 32'h4400_0000);
                send(4'b1001, 4'b0110, 32'h5500_0055);
            end
            begin
                repeat (6) @(negedge clk);
                chk("t5_accepted", 64'(accepted), 64'd2);
                chk("t5_in_ready", 64'(bus.in_ready), 64'd0);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("t5");
        chk("t5_pkt5", 64'(pkt_cnt), 64'(sx(5)));
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        send(4'b0011, 4'b0001, 32'h0000_BBAA);
        send(4'b0110, 4'b0010, 32'h00DD_CC00);
        chk("t6_full_idle", 64'(idle), 64'd0);
        do_reset();
        @(negedge clk);
        chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_idle", 64'(idle), 64'd1);
        chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t6_out_data", 64'(bus.out_data), 64'd0);
        chk("t6_out_len", 64'(bus.out_len), 64'd0);
        chk("t6_pkt", 64'(pkt_cnt), 64'd0);
        chk("t6_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(4'b1010, 4'b1100, 32'h7700_6600);
        latency2("t6");
        drain("t6");
        @(posedge clk);
        #1;

        rnd = 1;
        for (int n = 0; n < 200; n++) begin
            b = 4'($urandom_range(0, 15));
            e = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                b = 4'd0;
                e = 4'd0;
            end
            send(b, e, $urandom);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rnd = 0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
